// File: rtl/systolic_tile_engine.sv
// Output-stationary NxN systolic matrix-multiply tile computing C = A * B with a per-job inner dimension.
// Operands enter as skewed wavefronts; results are drained one row per valid/ready handshake.
module systolic_tile_engine #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int K_MAX      = 256,
    parameter int SIGNED     = 1,
    localparam int KW        = $clog2(K_MAX + 1),
    localparam int RW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [KW-1:0]             k_len,
    output logic                      busy,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N*DATA_WIDTH-1:0]   in_a,
    input  logic [N*DATA_WIDTH-1:0]   in_b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N*ACC_WIDTH-1:0]    out_data,
    output logic [RW-1:0]             out_row,
    output logic                      out_last
);
    localparam int FW = $clog2(2 * N);

    if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_bad_acc
        $error("ACC_WIDTH must be at least 2*DATA_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [KW-1:0]   k_lat, k_cnt, k_eff;
    logic [FW-1:0]   fl_cnt;
    logic [RW-1:0]   row;
    logic            adv, clr;

    logic [DATA_WIDTH-1:0] ska [N][N];
    logic [DATA_WIDTH-1:0] skb [N][N];
    logic [DATA_WIDTH-1:0] a_q [N][N];
    logic [DATA_WIDTH-1:0] b_q [N][N];
    logic [DATA_WIDTH-1:0] a_src [N];
    logic [DATA_WIDTH-1:0] b_src [N];
    logic [DATA_WIDTH-1:0] a_sk [N];
    logic [DATA_WIDTH-1:0] b_sk [N];
    logic [DATA_WIDTH-1:0] a_w [N][N];
    logic [DATA_WIDTH-1:0] b_n [N][N];
    logic [ACC_WIDTH-1:0]  acc [N][N];

    // Full-width product, sign- or zero-extended to the accumulator width.
    function automatic logic [ACC_WIDTH-1:0] prod_ext(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic signed [2*DATA_WIDTH-1:0] ps;
        logic        [2*DATA_WIDTH-1:0] pu;
        ps = $signed(a) * $signed(b);
        pu = a * b;
        if (SIGNED != 0) return ACC_WIDTH'(ps);
        return ACC_WIDTH'(pu);
    endfunction

    assign k_eff = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;

    // Edge feed: live operands in LOAD, zeros while flushing; row/column i delayed i steps.
    for (genvar i = 0; i < N; i++) begin : g_edge
        assign a_src[i] = (state == LOAD) ? in_a[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign b_src[i] = (state == LOAD) ? in_b[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        if (i == 0) begin : g_nodly
            assign a_sk[i] = a_src[i];
            assign b_sk[i] = b_src[i];
        end else begin : g_dly
            assign a_sk[i] = ska[i][i-1];
            assign b_sk[i] = skb[i][i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j == 0) begin : g_aw0
                assign a_w[i][j] = a_sk[i];
            end else begin : g_awn
                assign a_w[i][j] = a_q[i][j-1];
            end
            if (i == 0) begin : g_bn0
                assign b_n[i][j] = b_sk[j];
            end else begin : g_bnn
                assign b_n[i][j] = b_q[i-1][j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    ska[i][j] <= '0;
                    skb[i][j] <= '0;
                    a_q[i][j] <= '0;
                    b_q[i][j] <= '0;
                    acc[i][j] <= '0;
                end
            end
        end else if (adv) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_q[i][j] <= a_w[i][j];
                    b_q[i][j] <= b_n[i][j];
                    acc[i][j] <= acc[i][j] + prod_ext(a_w[i][j], b_n[i][j]);
                end
                if (i > 0) begin
                    ska[i][0] <= a_src[i];
                    skb[i][0] <= b_src[i];
                end
                for (int d = 1; d < N; d++) begin
                    if (d < i) begin
                        ska[i][d] <= ska[i][d-1];
                        skb[i][d] <= skb[i][d-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            k_lat  <= '0;
            k_cnt  <= '0;
            fl_cnt <= '0;
            row    <= '0;
        end else begin
            state <= state_nxt;
            if (clr) begin
                k_lat <= k_eff;
                k_cnt <= '0;
            end else if (state == LOAD && in_valid) begin
                k_cnt <= k_cnt + KW'(1);
            end
            fl_cnt <= (state == FLUSH) ? fl_cnt + FW'(1) : '0;
            if (state != DRAIN || (out_ready && row == RW'(N - 1))) row <= '0;
            else if (out_ready) row <= row + RW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        adv       = 1'b0;
        clr       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    clr       = 1'b1;
                    state_nxt = (k_eff == '0) ? DRAIN : LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                adv      = in_valid;
                if (in_valid && k_cnt == k_lat - KW'(1)) state_nxt = FLUSH;
            end
            FLUSH: begin
                adv = 1'b1;
                if (fl_cnt == FW'(2 * N - 2)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (out_ready && row == RW'(N - 1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == DRAIN);
    assign out_row   = row;
    assign out_last  = out_valid && (row == RW'(N - 1));

    for (genvar j = 0; j < N; j++) begin : g_out
        assign out_data[j*ACC_WIDTH +: ACC_WIDTH] = out_valid ? acc[row][j] : '0;
    end

endmodule

// File: tb/tb_systolic_tile_engine.sv
// Directed bench for systolic_tile_engine: signed and unsigned instances share stimulus,
// a reference model pushes expected rows to scoreboard queues that the drain handshakes pop.
module tb_systolic_tile_engine;
    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int AW   = 32;
    localparam int KMAX = 256;
    localparam int KW   = 9;
    localparam int RW   = 2;
    localparam int CW   = 160;

    logic              clk = 1'b0;
    logic              rst, start, in_valid, out_ready;
    logic [KW-1:0]     k_len;
    logic [N*DW-1:0]   in_a, in_b;
    logic              busy, in_ready, out_valid, out_last;
    logic [N*AW-1:0]   out_data;
    logic [RW-1:0]     out_row;
    logic              busy_u, in_ready_u, out_valid_u, out_last_u;
    logic [N*AW-1:0]   out_data_u;
    logic [RW-1:0]     out_row_u;

    always #5 clk = ~clk;

    systolic_tile_engine #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(KMAX), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_last(out_last));

    systolic_tile_engine #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(KMAX), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy_u),
        .in_valid(in_valid), .in_ready(in_ready_u), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u),
        .out_row(out_row_u), .out_last(out_last_u));

    logic [DW-1:0]   ma [N][KMAX];
    logic [DW-1:0]   mb [KMAX][N];
    logic [N*AW-1:0] q_s[$];
    logic [N*AW-1:0] q_u[$];
    int checks = 0;
    int errors = 0;
    int beats = 0;
    int ready_cycles = 0;

    always @(posedge clk) begin
        if (in_valid && in_ready) beats <= beats + 1;
        if (in_ready) ready_cycles <= ready_cycles + 1;
    end

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_const(input logic [DW-1:0] a, input logic [DW-1:0] b);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < KMAX; k++) begin
                ma[i][k] = a;
                mb[k][i] = b;
            end
    endtask

    task automatic fill_identity();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < KMAX; k++) begin
                ma[i][k] = (i == k) ? 8'd1 : 8'd0;
                mb[k][i] = 8'(4 * k + i + 1);
            end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < KMAX; k++) begin
                ma[i][k] = 8'($urandom);
                mb[k][i] = 8'($urandom);
            end
    endtask

    task automatic push_expected(input int k);
        logic [N*AW-1:0] rs, ru;
        int s, u;
        for (int r = 0; r < N; r++) begin
            rs = '0;
            ru = '0;
            for (int j = 0; j < N; j++) begin
                s = 0;
                u = 0;
                for (int kk = 0; kk < k; kk++) begin
                    s += int'($signed(ma[r][kk])) * int'($signed(mb[kk][j]));
                    u += int'(ma[r][kk]) * int'(mb[kk][j]);
                end
                rs[j*AW +: AW] = s;
                ru[j*AW +: AW] = u;
            end
            q_s.push_back(rs);
            q_u.push_back(ru);
        end
    endtask

    task automatic drive_beat(input int kk);
        for (int i = 0; i < N; i++) begin
            in_a[i*DW +: DW] = ma[i][kk];
            in_b[i*DW +: DW] = mb[kk][i];
        end
    endtask

    task automatic run_job(input int kin, input bit gaps, input bit stall, input bit pulse);
        int keff, kk, guard, lat, b0, r0, g;
        logic [N*AW-1:0] es, eu, d0;
        logic [RW-1:0] w0;
        keff = (kin > KMAX) ? KMAX : kin;
        push_expected(keff);
        b0 = beats;
        r0 = ready_cycles;
        start = 1'b1;
        k_len = KW'(kin);
        tick();
        start = 1'b0;
        kk = 0;
        guard = 0;
        while (kk < keff && guard < 5000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pulse && kk == 0) begin
                start = 1'b1;
                k_len = KW'(7);
            end else begin
                start = 1'b0;
            end
            if (in_valid) drive_beat(kk);
            else begin
                in_a = $urandom;
                in_b = $urandom;
            end
            if (in_valid && in_ready) kk++;
            tick();
            guard++;
        end
        start = 1'b0;
        check("load_beats_sent", kk, keff);
        in_valid = 1'b1;
        in_a = $urandom;
        in_b = $urandom;
        if (keff > 0) begin
            lat = 1;
            while (!out_valid && lat < 200) begin
                tick();
                lat++;
            end
            check("first_valid_latency", lat, 2 * N);
        end else begin
            check("k0_direct_drain", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        for (int r = 0; r < N; r++) begin
            g = 0;
            while (!out_valid && g < 50) begin
                tick();
                g++;
            end
            check("row_valid", out_valid, 1'b1);
            if (stall) begin
                out_ready = 1'b0;
                d0 = out_data;
                w0 = out_row;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check("stall_hold", {out_valid, out_row, out_data}, {1'b1, w0, d0});
                end
            end
            out_ready = 1'b1;
            es = (q_s.size() > 0) ? q_s.pop_front() : '1;
            eu = (q_u.size() > 0) ? q_u.pop_front() : '1;
            check("row_data_signed", out_data, es);
            check("row_data_unsigned", out_data_u, eu);
            check("out_row", out_row, r);
            check("out_last", out_last, (r == N - 1));
            check("twin_ctrl", {out_valid_u, out_row_u, out_last_u, busy_u, in_ready_u},
                  {out_valid, out_row, out_last, busy, in_ready});
            tick();
            if (stall) out_ready = 1'b0;
        end
        out_ready = 1'b0;
        check("valid_after_drain", out_valid, 1'b0);
        check("busy_after_drain", busy, 1'b0);
        check("accepted_beats", beats - b0, keff);
        if (keff == 0) check("k0_no_ready", ready_cycles - r0, 0);
        check("scoreboard_empty", q_s.size() + q_u.size(), 0);
        q_s.delete();
        q_u.delete();
    endtask

    initial begin
        int stale;
        rst = 1'b1;
        start = 1'b1;
        k_len = KW'(4);
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        start = 1'b0;
        check("reset_busy", busy, 1'b0);
        check("reset_in_ready", in_ready, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_last", out_last, 1'b0);
        check("reset_out_row", out_row, 0);
        check("reset_out_data", out_data, 0);

        fill_identity();
        run_job(4, 1'b0, 1'b0, 1'b0);

        run_job(0, 1'b0, 1'b0, 1'b0);

        fill_const(8'h80, 8'h80);
        run_job(256, 1'b0, 1'b0, 1'b0);
        fill_const(8'hFF, 8'hFF);
        run_job(300, 1'b0, 1'b0, 1'b0);

        fill_random();
        run_job(8, 1'b0, 1'b0, 1'b0);
        run_job(8, 1'b1, 1'b0, 1'b0);

        fill_random();
        run_job(5, 1'b0, 1'b1, 1'b0);

        // Abort a job on its third beat, then run a fresh one.
        fill_identity();
        start = 1'b1;
        k_len = KW'(4);
        tick();
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1;
            drive_beat(b);
            tick();
        end
        rst = 1'b1;
        drive_beat(2);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_in_ready", in_ready, 1'b0);
        stale = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (out_valid) stale++;
        end
        check("abort_no_stale_rows", stale, 0);
        fill_const(8'h01, 8'h01);
        run_job(1, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
